// File: rtl/fp8_mul_rr_scheduler.sv
// Round-robin front end that shares one combinational E4M3 multiplier among NUM_REQ lanes,
// with a two-stage valid/ready pipeline and free-running utilisation counters.

module fp8_e4m3_multiplier (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_p
);
  logic       w_sign;
  logic       w_zero;
  logic [4:0] w_hi;
  logic [6:0] w_exp;
  logic [2:0] w_mant;

  assign w_sign = i_a[7] ^ i_b[7];
  assign w_zero = (i_a[6:3] == 4'd0) || (i_b[6:3] == 4'd0);
  // Only product bits [7:3] matter: bit 7 selects normalisation, the rest feed the truncated mantissa.
  assign w_hi   = 5'(({4'b0, 1'b1, i_a[2:0]} * {4'b0, 1'b1, i_b[2:0]}) >> 3);
  assign w_exp  = {3'b0, i_a[6:3]} + {3'b0, i_b[6:3]} + {6'b0, w_hi[4]} - 7'd7;
  assign w_mant = w_hi[4] ? w_hi[3:1] : w_hi[2:0];

  always_comb begin
    o_p = {w_sign, 7'h00};
    if (!w_zero && !w_exp[6] && (w_exp != 7'd0)) begin
      if (w_exp > 7'd14) begin
        o_p = {w_sign, 4'hE, 3'h7};
      end else begin
        o_p = {w_sign, w_exp[3:0], w_mant};
      end
    end
  end
endmodule

module fp8_mul_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  input  logic                 rsp_ready,
  output logic [CNT_W-1:0]     op_count,
  output logic [CNT_W-1:0]     stall_count
);
  localparam logic [ID_W:0]   NUM_REQ_EXT = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_LANE   = ID_W'(NUM_REQ - 1);

  logic                 r_s1_valid;
  logic [7:0]           r_s1_a;
  logic [7:0]           r_s1_b;
  logic [ID_W-1:0]      r_s1_id;
  logic [ID_W-1:0]      r_rr_ptr;
  logic                 r_rsp_valid;
  logic [7:0]           r_rsp_data;
  logic [ID_W-1:0]      r_rsp_id;
  logic [CNT_W-1:0]     r_op_count;
  logic [CNT_W-1:0]     r_stall_count;

  logic                 w_s2_free;
  logic                 w_s1_adv;
  logic                 w_s1_free;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [ID_W-1:0]      w_off;
  logic [ID_W:0]        w_sum;
  logic [ID_W-1:0]      w_winner;
  logic                 w_any;
  logic                 w_accept;
  logic [ID_W-1:0]      w_ptr_next;
  logic [7:0]           w_sel_a;
  logic [7:0]           w_sel_b;
  logic [7:0]           w_prod;

  assign w_s2_free = !r_rsp_valid || rsp_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_free;
  assign w_s1_free = !r_s1_valid || w_s1_adv;

  // Rotate requests so the pointer lane sits at bit 0, then take the lowest set bit.
  assign w_dbl = {req_valid, req_valid} >> r_rr_ptr;
  assign w_rot = w_dbl[NUM_REQ-1:0];
  assign w_any = |req_valid;

  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = ID_W'(k);
      end
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum >= NUM_REQ_EXT) begin
      w_sum = w_sum - NUM_REQ_EXT;
    end
    w_winner = w_sum[ID_W-1:0];
  end

  assign req_ready  = (w_any && w_s1_free && rst_n) ? (NUM_REQ'(1) << w_winner) : '0;
  assign w_accept   = |(req_valid & req_ready);
  assign w_ptr_next = (w_winner == LAST_LANE) ? '0 : w_winner + ID_W'(1);
  assign w_sel_a    = req_a[{w_winner, 3'b000} +: 8];
  assign w_sel_b    = req_b[{w_winner, 3'b000} +: 8];

  fp8_e4m3_multiplier u_mul (
    .i_a (r_s1_a),
    .i_b (r_s1_b),
    .o_p (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_a        <= 8'h00;
      r_s1_b        <= 8'h00;
      r_s1_id       <= '0;
      r_rr_ptr      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= 8'h00;
      r_rsp_id      <= '0;
      r_op_count    <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_a     <= w_sel_a;
        r_s1_b     <= w_sel_b;
        r_s1_id    <= w_winner;
        r_rr_ptr   <= w_ptr_next;
        r_op_count <= r_op_count + CNT_W'(1);
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_free) begin
        r_rsp_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_rsp_data <= w_prod;
          r_rsp_id   <= r_s1_id;
        end
      end
      if (r_rsp_valid && !rsp_ready) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_id      = r_rsp_id;
  assign op_count    = r_op_count;
  assign stall_count = r_stall_count;
endmodule

// File: doc/fp8_mul_rr_scheduler.md
# fp8_mul_rr_scheduler

Round-robin scheduler that shares one `fp8_e4m3_multiplier` datapath among `NUM_REQ` requesters. It sits between per-lane FP8 producers and a single pipelined multiplier. The block arbitrates valid/ready requests, tags each accepted operation with its requester ID, and returns the results in issue order through a backpressured response port. It also keeps free-running utilisation counters for performance monitoring.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester tag.
- `CNT_W`, default 16: width of the performance counters.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  `NUM_REQ`: per-requester request pending.
- `req_a`  in  `NUM_REQ*8`: operand A, E4M3; lane i occupies `[8i+7:8i]`.
- `req_b`  in  `NUM_REQ*8`: operand B, same packing as `req_a`.
- `req_ready`  out  `NUM_REQ`: grant; at most one bit set (one-hot or zero).
- `rsp_valid`  out  1: result available.
- `rsp_data`  out  8: E4M3 product.
- `rsp_id`  out  `ID_W`: index of the requester that issued this result.
- `rsp_ready`  in  1: consumer accepts the result.
- `op_count`  out  `CNT_W`: number of accepted operations; wraps.
- `stall_count`  out  `CNT_W`: cycles with `rsp_valid && !rsp_ready`; wraps.

## Operation
- **Pipeline.** Two registered stages.
  - S1 holds the registered operands, ID and `s1_valid`.
  - One combinational `fp8_e4m3_multiplier` instance sits between S1 and S2, unmodified.
  - S2 holds `rsp_data`, `rsp_id` and `rsp_valid`.
- **Advance rules.**
  - `s2_free = !rsp_valid || rsp_ready`.
  - `s1_adv = s1_valid && s2_free`.
  - `s1_free = !s1_valid || s1_adv`.
- **Arbitration.** Round-robin with a pointer `rr_ptr`.
  - Search order is `rr_ptr`, `rr_ptr+1`, … modulo `NUM_REQ`.
  - The first lane with `req_valid` set is the winner.
  - `req_ready[winner] = s1_free`; all other `req_ready` bits are 0.
  - `req_ready` is combinational from `req_valid` and the pipeline state.
- **Accept.** An accept occurs when `req_valid[i] && req_ready[i]`. On the same edge:
  - S1 loads `req_a[i]`, `req_b[i]` and `i`.
  - `rr_ptr` ← (i+1) mod `NUM_REQ`.
  - `op_count` increments.
- **Pointer hold.** `rr_ptr` changes only on an accept.
- **Requester rules.** A requester holds `req_valid` and its operands stable until it is granted. The block does not require this and does not check it.
- **Multiplier semantics (inherited; the bench checks exactly these).**
  - Sign of the product = `sign_a ^ sign_b`, including for zero results.
  - An operand with exponent 0 (zero or denormal) forces a zero magnitude.
  - Normalised exponent > 14 saturates the magnitude to exp 14, mant 7.
  - Normalised exponent < 1 flushes the magnitude to zero.
  - Mantissa is truncated, not rounded.
  - NaN encodings are not special-cased.
- **In-order delivery.** Results leave in accept order. The block holds at most two operations in flight.
- **Stall counter.** `stall_count` increments on every cycle with `rsp_valid && !rsp_ready`, saturating never (wraps modulo 2^`CNT_W`).

## Timing
- **Reset values.**
  - `rsp_valid` = 0, `rsp_data` = 0x00, `rsp_id` = 0.
  - `s1_valid` = 0, `rr_ptr` = 0.
  - `op_count` = 0, `stall_count` = 0.
  - `req_ready` is forced to 0 while `rst_n` is low.
- **Latency.** An accept at edge k gives `rsp_valid` high after edge k+1 when `rsp_ready` was high, i.e. 2 registered stages with the result visible in the cycle after the operand register loads.
- **Throughput.** One op per cycle sustained while `rsp_ready` = 1.
- **Backpressure.**
  - With `rsp_ready` = 0, S2 holds and S1 fills.
  - `req_ready` is then all-zero until `rsp_ready` returns.
  - Accepted data is never dropped or duplicated.
- **Simultaneous events.**
  - When `rsp_ready` and S1 advance coincide with a new accept, all three transfers happen on the same edge.
  - When all lanes are valid, grants rotate i, i+1, … with no lane granted twice before every other valid lane has been granted once.
- **Reset mid-operation.** Asserting `rst_n` clears all valids immediately (asynchronously) and discards in-flight ops. Counters and pointer return to 0.
- **Wrap-around.**
  - `rr_ptr` wraps from `NUM_REQ-1` to 0.
  - Counters wrap from all-ones to 0 without flagging.

## Test plan
- **Single op.** Lane 2 issues 0x3C×0x3C with `rsp_ready`=1 -> one cycle later `rsp_valid`=1, `rsp_data`=0x41, `rsp_id`=2, `op_count`=1.
- **Sign, zero and saturation.**
  - 0xB8×0x38 -> 0xB8.
  - 0x80×0x48 -> 0x80.
  - 0x70×0x70 -> 0x77.
  - 0x40×0x40 -> 0x48.
  - 0x08×0x08 -> 0x00.
- **Round-robin.** All 4 lanes valid continuously from reset, `rsp_ready`=1 -> grants 0,1,2,3,0,1…; `rsp_id` sequence matches; one result per cycle.
- **Backpressure.** Lanes 0 and 1 valid, `rsp_ready`=0 for 5 cycles -> two ops accepted, then `req_ready`=0; `stall_count`=4 or 5 per the cycle definition; after `rsp_ready`=1 both results emerge in order, no loss.
- **Reset mid-flight.** Assert `rst_n`=0 with S1 and S2 full -> `rsp_valid`=0 immediately, `op_count`=0; the next accept after release goes to lowest valid lane from index 0.
- **Counter wrap.** `CNT_W`=4, 17 accepts -> `op_count`=1.
